// File: rtl/addr_gen_hc_wr_if.sv
// Handshake/bus bundle between the LSTM cell output pipeline and the
// H/C write-address generator. The generator uses the slave modport.
interface addr_gen_hc_wr_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  en;
    logic                  i_valid_c;
    logic                  i_valid_h;
    logic [ADDR_WIDTH-1:0] o_addr_c;
    logic                  o_we_c;
    logic [ADDR_WIDTH-1:0] o_addr_h;
    logic                  o_we_h;
    logic                  o_zero;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    modport master (
        output en, i_valid_c, i_valid_h,
        input  o_addr_c, o_we_c, o_addr_h, o_we_h, o_zero, o_busy, o_done, o_err
    );

    modport slave (
        input  en, i_valid_c, i_valid_h,
        output o_addr_c, o_we_c, o_addr_h, o_we_h, o_zero, o_busy, o_done, o_err
    );
endinterface

// File: rtl/addr_gen_hc_wr.sv
// Write-address generator for the H and C state memories in forward
// propagation. Zero-fills the t = -1 slots of both memories, then hands out
// one sequential write address per valid strobe until every timestep is
// written. All outputs are registered.
module addr_gen_hc_wr #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMESTEP   = 7,
    parameter int NUM_CELL   = 8
) (
    input  logic               clk,
    input  logic               rst,
    addr_gen_hc_wr_if.slave    bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(NUM_CELL * (TIMESTEP + 1) - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_END = ADDR_WIDTH'(NUM_CELL - 1);
    localparam logic [ADDR_WIDTH-1:0] RUN_BASE = ADDR_WIDTH'(NUM_CELL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ZERO = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ptr_c_q;
    logic [ADDR_WIDTH-1:0] ptr_h_q;
    logic                  full_c_q;
    logic                  full_h_q;
    logic [ADDR_WIDTH-1:0] addr_c_q;
    logic [ADDR_WIDTH-1:0] addr_h_q;
    logic                  we_c_q;
    logic                  we_h_q;
    logic                  zero_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic                  acc_c_d;
    logic                  acc_h_d;
    logic                  proto_err_d;

    // Accept/reject decision for the RUN-phase strobes. Pointers only ever
    // satisfy ptr_h <= ptr_c, so inequality means H is strictly behind C.
    always_comb begin
        acc_c_d     = 1'b0;
        acc_h_d     = 1'b0;
        proto_err_d = 1'b0;
        if (state_q == S_RUN) begin
            acc_c_d     = bus.i_valid_c & ~full_c_q;
            acc_h_d     = bus.i_valid_h & ~full_h_q & ((ptr_h_q != ptr_c_q) | acc_c_d);
            proto_err_d = (bus.i_valid_c & ~acc_c_d) | (bus.i_valid_h & ~acc_h_d);
        end else begin
            acc_c_d     = 1'b0;
            acc_h_d     = 1'b0;
            proto_err_d = 1'b0;
        end
    end

    // Main FSM: phase sequencing, pointers and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ptr_c_q  <= '0;
            ptr_h_q  <= '0;
            full_c_q <= 1'b0;
            full_h_q <= 1'b0;
            addr_c_q <= '0;
            addr_h_q <= '0;
            we_c_q   <= 1'b0;
            we_h_q   <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (!bus.en) begin
            state_q  <= S_IDLE;
            ptr_c_q  <= '0;
            ptr_h_q  <= '0;
            full_c_q <= 1'b0;
            full_h_q <= 1'b0;
            addr_c_q <= '0;
            addr_h_q <= '0;
            we_c_q   <= 1'b0;
            we_h_q   <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Valids here are ignored; first zero-fill address goes out now.
                    state_q  <= S_ZERO;
                    addr_c_q <= '0;
                    addr_h_q <= '0;
                    we_c_q   <= 1'b1;
                    we_h_q   <= 1'b1;
                    zero_q   <= 1'b1;
                    busy_q   <= 1'b1;
                end
                S_ZERO: begin
                    if (bus.i_valid_c || bus.i_valid_h) begin
                        err_q <= 1'b1;
                    end else begin
                        err_q <= err_q;
                    end
                    if (addr_c_q == ZERO_END) begin
                        state_q <= S_RUN;
                        we_c_q  <= 1'b0;
                        we_h_q  <= 1'b0;
                        zero_q  <= 1'b0;
                        ptr_c_q <= RUN_BASE;
                        ptr_h_q <= RUN_BASE;
                    end else begin
                        addr_c_q <= addr_c_q + ADDR_WIDTH'(1);
                        addr_h_q <= addr_h_q + ADDR_WIDTH'(1);
                    end
                end
                S_RUN: begin
                    if (full_c_q && full_h_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        we_c_q  <= 1'b0;
                        we_h_q  <= 1'b0;
                        if (bus.i_valid_c || bus.i_valid_h) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= err_q;
                        end
                    end else begin
                        we_c_q <= acc_c_d;
                        we_h_q <= acc_h_d;
                        if (acc_c_d) begin
                            addr_c_q <= ptr_c_q;
                            ptr_c_q  <= ptr_c_q + ADDR_WIDTH'(1);
                            full_c_q <= (ptr_c_q == LAST);
                        end else begin
                            addr_c_q <= addr_c_q;
                        end
                        if (acc_h_d) begin
                            addr_h_q <= ptr_h_q;
                            ptr_h_q  <= ptr_h_q + ADDR_WIDTH'(1);
                            full_h_q <= (ptr_h_q == LAST);
                        end else begin
                            addr_h_q <= addr_h_q;
                        end
                        if (proto_err_d) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= err_q;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.i_valid_c || bus.i_valid_h) begin
                        err_q <= 1'b1;
                    end else begin
                        err_q <= err_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    we_c_q  <= 1'b0;
                    we_h_q  <= 1'b0;
                    zero_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_addr_c = addr_c_q;
    assign bus.o_addr_h = addr_h_q;
    assign bus.o_we_c   = we_c_q;
    assign bus.o_we_h   = we_h_q;
    assign bus.o_zero   = zero_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_err    = err_q;

endmodule

// File: tb/tb_addr_gen_hc_wr.sv
// Bench for addr_gen_hc_wr: directed scenarios plus a randomized phase,
// every cycle compared against a count-based reference model.
module tb_addr_gen_hc_wr;
    localparam int AW = 12;
    localparam int TS = 7;
    localparam int NC = 8;
    localparam int NW = NC * TS;

    localparam int M_IDLE = 0;
    localparam int M_ZERO = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // model state: phase, zero-fill index, per-stream write counts
    int   m_phase;
    int   m_z;
    int   m_cc;
    int   m_ch;
    int   m_addr_c;
    int   m_addr_h;
    logic m_we_c, m_we_h, m_zero, m_busy, m_done, m_err;

    addr_gen_hc_wr_if #(.ADDR_WIDTH(AW)) bus ();

    addr_gen_hc_wr #(.ADDR_WIDTH(AW), .TIMESTEP(TS), .NUM_CELL(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_phase = M_IDLE; m_z = 0; m_cc = 0; m_ch = 0;
        m_addr_c = 0; m_addr_h = 0;
        m_we_c = 1'b0; m_we_h = 1'b0; m_zero = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    endtask

    // One rising edge of the reference behaviour, given the sampled inputs.
    task automatic model_edge(input logic e, input logic vc, input logic vh);
        bit c_ok, h_ok;
        if (!e) begin
            model_clear();
        end else if (m_phase == M_IDLE) begin
            m_phase = M_ZERO; m_z = 0;
            m_addr_c = 0; m_addr_h = 0;
            m_we_c = 1'b1; m_we_h = 1'b1; m_zero = 1'b1; m_busy = 1'b1;
        end else if (m_phase == M_ZERO) begin
            if (vc || vh) m_err = 1'b1;
            if (m_z == NC - 1) begin
                m_phase = M_RUN; m_cc = 0; m_ch = 0;
                m_we_c = 1'b0; m_we_h = 1'b0; m_zero = 1'b0;
            end else begin
                m_z++;
                m_addr_c = m_z; m_addr_h = m_z;
            end
        end else if (m_phase == M_RUN) begin
            if (m_cc == NW && m_ch == NW) begin
                m_phase = M_DONE; m_done = 1'b1; m_busy = 1'b0;
                m_we_c = 1'b0; m_we_h = 1'b0;
                if (vc || vh) m_err = 1'b1;
            end else begin
                c_ok = vc && (m_cc < NW);
                h_ok = vh && (m_ch < NW) && ((m_ch < m_cc) || c_ok);
                if ((vc && !c_ok) || (vh && !h_ok)) m_err = 1'b1;
                m_we_c = c_ok; m_we_h = h_ok;
                if (c_ok) begin m_addr_c = NC + m_cc; m_cc++; end
                if (h_ok) begin m_addr_h = NC + m_ch; m_ch++; end
            end
        end else begin
            if (vc || vh) m_err = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".we_c"}, int'(bus.o_we_c), int'(m_we_c));
        chk({tag, ".we_h"}, int'(bus.o_we_h), int'(m_we_h));
        chk({tag, ".zero"}, int'(bus.o_zero), int'(m_zero));
        chk({tag, ".busy"}, int'(bus.o_busy), int'(m_busy));
        chk({tag, ".done"}, int'(bus.o_done), int'(m_done));
        chk({tag, ".err"},  int'(bus.o_err),  int'(m_err));
        if (m_phase != M_IDLE) begin
            chk({tag, ".addr_c"}, int'(bus.o_addr_c), m_addr_c);
            chk({tag, ".addr_h"}, int'(bus.o_addr_h), m_addr_h);
        end
    endtask

    task automatic step(input string tag, input logic e, input logic vc, input logic vh);
        bus.en = e; bus.i_valid_c = vc; bus.i_valid_h = vh;
        @(posedge clk);
        model_edge(e, vc, vh);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic zero_fill(input string tag);
        for (int i = 0; i < NC + 1; i++) step(tag, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0;
        model_clear();
        rst = 1'b0;
        bus.en = 1'b0; bus.i_valid_c = 1'b0; bus.i_valid_h = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset.addr_c", int'(bus.o_addr_c), 0);
        chk("reset.addr_h", int'(bus.o_addr_h), 0);
        rst = 1'b1;
        step("idle", 1'b0, 1'b1, 1'b1);

        // zero-fill, then continuous lockstep writes to DONE
        step("zf_first", 1'b1, 1'b0, 1'b0);
        chk("zf_first.addr0", int'(bus.o_addr_c), 0);
        for (int i = 1; i < NC + 1; i++) step("zf", 1'b1, 1'b0, 1'b0);
        chk("run_entry.busy", int'(bus.o_busy), 1);
        for (int i = 0; i < NW; i++) step("cont", 1'b1, 1'b1, 1'b1);
        chk("cont.last_addr", int'(bus.o_addr_h), NC * (TS + 1) - 1);
        step("cont_done", 1'b1, 1'b0, 1'b0);
        chk("cont.done", int'(bus.o_done), 1);
        chk("cont.no_err", int'(bus.o_err), 0);
        step("done_valid", 1'b1, 1'b1, 1'b0);
        chk("done_valid.err", int'(bus.o_err), 1);
        step("done_hold", 1'b1, 1'b0, 1'b0);
        step("drop_en", 1'b0, 1'b0, 1'b0);

        // C leads H by 3 cycles, gap every 5th cycle
        zero_fill("lead_zf");
        for (int t = 0; t < 200 && !m_done; t++) begin
            step("lead", 1'b1, (t % 5 != 4) && (m_cc < NW),
                 (t >= 3) && (t % 5 != 4) && (m_ch < NW));
        end
        chk("lead.done", int'(bus.o_done), 1);
        chk("lead.no_err", int'(bus.o_err), 0);
        step("drop_en2", 1'b0, 1'b0, 1'b0);

        // H with no prior C is rejected and err is sticky
        zero_fill("horph_zf");
        step("h_orphan", 1'b1, 1'b0, 1'b1);
        chk("h_orphan.err", int'(bus.o_err), 1);
        chk("h_orphan.we_h", int'(bus.o_we_h), 0);
        step("h_orphan_hold", 1'b1, 1'b0, 1'b0);
        step("err_clear", 1'b0, 1'b0, 1'b0);
        chk("err_clear.err", int'(bus.o_err), 0);
        step("restart", 1'b1, 1'b0, 1'b0);
        chk("restart.addr0", int'(bus.o_addr_c), 0);
        for (int i = 1; i < NC + 1; i++) step("restart_zf", 1'b1, 1'b0, 1'b0);

        // abort after 20 C writes, then restart
        for (int i = 0; i < 20; i++) step("abort_c", 1'b1, 1'b1, 1'b0);
        chk("abort_c.addr", int'(bus.o_addr_c), NC + 19);
        step("abort", 1'b0, 1'b1, 1'b0);
        zero_fill("abort_zf");
        step("abort_first", 1'b1, 1'b1, 1'b1);
        chk("abort_first.addr_c", int'(bus.o_addr_c), NC);

        // asynchronous reset mid-RUN at address 30
        for (int i = 0; i < 200 && m_cc < 23; i++) step("pre_rst", 1'b1, 1'b1, 1'b1);
        chk("pre_rst.addr", int'(bus.o_addr_c), 30);
        #2 rst = 1'b0;
        #1;
        model_clear();
        check_all("async_rst");
        chk("async_rst.addr_c", int'(bus.o_addr_c), 0);
        chk("async_rst.addr_h", int'(bus.o_addr_h), 0);
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 1'b1, 1'b0, 1'b0);
        chk("post_rst.zero", int'(bus.o_zero), 1);

        // randomized traffic, including errors and en drops
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 149) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
